// File: rtl/iv_path_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the IV path sequencer.
package iv_path_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        VERIFY  = 2'd2,
        RELEASE = 2'd3
    } pathState_t;

    localparam int DefORAML      = 10;
    localparam int DefBktBursts  = 5;
    localparam int DefPathBursts = (DefORAML + 1) * DefBktBursts;

    function automatic int pathBursts(input int oraml, input int bktBursts);
        return (oraml + 1) * bktBursts;
    endfunction

endpackage

// File: rtl/iv_path_sequencer_if.sv
// Path and bucket-of-interest handshake bundle between the sequencer,
// the DRAM read side and the integrity verifier.
interface iv_path_sequencer_if #(
    parameter int ORAML = 10
);
    localparam int LvlW = $clog2(ORAML + 1);

    logic            FillValid;
    logic            PathStart;
    logic            PathReady;
    logic            PathDone;
    logic            PathRelease;
    logic            ROIValid;
    logic            ROIReady;
    logic [LvlW-1:0] ROILevelIn;
    logic [63:0]     ROIBVIn;
    logic [ORAML:0]  ROIBIDIn;
    logic            BOIReady;
    logic [LvlW-1:0] ROILevel;
    logic [63:0]     ROIBV;
    logic [ORAML:0]  ROIBID;
    logic            BOIDone;
    logic            SeqError;

    modport master (
        output FillValid, PathStart, PathDone,
        output ROIValid, ROILevelIn, ROIBVIn, ROIBIDIn, BOIDone,
        input  PathReady, PathRelease, ROIReady, BOIReady,
        input  ROILevel, ROIBV, ROIBID, SeqError
    );

    modport slave (
        input  FillValid, PathStart, PathDone,
        input  ROIValid, ROILevelIn, ROIBVIn, ROIBIDIn, BOIDone,
        output PathReady, PathRelease, ROIReady, BOIReady,
        output ROILevel, ROIBV, ROIBID, SeqError
    );

endinterface

// File: rtl/iv_path_sequencer_boi.sv
// Bucket-of-interest latch: one outstanding request, descriptor held
// until the verifier reports done (not before two cycles after BOIReady).
module iv_boi_latch
    import iv_path_sequencer_pkg::*;
#(
    parameter int LvlW = 4,
    parameter int BidW = 11
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            ROIValid,
    output logic            ROIReady,
    input  logic [LvlW-1:0] levelIn,
    input  logic [63:0]     bvIn,
    input  logic [BidW-1:0] bidIn,
    output logic            BOIReady,
    output logic [LvlW-1:0] level,
    output logic [63:0]     bv,
    output logic [BidW-1:0] bid,
    input  logic            BOIDone,
    output logic            busy
);

    logic [1:0] age;

    assign ROIReady = !busy;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy     <= 1'b0;
            BOIReady <= 1'b0;
            age      <= 2'd0;
            level    <= '0;
            bv       <= '0;
            bid      <= '0;
        end else begin
            BOIReady <= 1'b0;
            if (ROIValid && !busy) begin
                level    <= levelIn;
                bv       <= bvIn;
                bid      <= bidIn;
                busy     <= 1'b1;
                BOIReady <= 1'b1;
                age      <= 2'd0;
            end else if (busy) begin
                // age saturates at 2: BOIDone only counts once the verifier settled
                if (BOIDone && age == 2'd2)
                    busy <= 1'b0;
                else if (age != 2'd2)
                    age <= age + 2'd1;
            end
        end
    end

endmodule

// File: rtl/iv_path_sequencer.sv
// Path buffer sequencer: fill -> verify -> release FSM plus BOI channel.
// Optional IV watchdog enabled by defining IVSEQ_WATCHDOG_EN.
module iv_path_sequencer
    import iv_path_sequencer_pkg::*;
#(
    parameter int ORAML            = 10,
    parameter int BktSize_DRBursts = 5,
    parameter int TimeoutCycles    = 4096
) (
    input  logic Clock,
    input  logic Reset,
    iv_path_sequencer_if.slave io
);

    localparam int PathBursts = pathBursts(ORAML, BktSize_DRBursts);
    localparam int CntW       = $clog2(PathBursts + 1);
    localparam int LvlW       = $clog2(ORAML + 1);
    localparam logic [CntW-1:0] LastBurst = CntW'(PathBursts - 1);

    if (TimeoutCycles < 1) begin : gBadTimeout
        $error("TimeoutCycles must be at least 1");
    end

    pathState_t      state, stateNext;
    logic [CntW-1:0] burstCnt, burstCntNext;
    logic            settled;
    logic            seqErr;
    logic            errSet;
    logic            pathReady, pathRelease;
    logic            boiBusy;
    logic            hold;
    logic            wdHit;

`ifdef IVSEQ_WATCHDOG_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);

    logic [WdW-1:0] wdCnt;
    logic           wdActive;
    logic           timedOut;

    assign wdActive = (state == VERIFY) || boiBusy;
    assign wdHit    = wdActive && !timedOut &&
                      (wdCnt == WdW'(TimeoutCycles - 1));
    assign hold     = timedOut;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wdCnt    <= '0;
            timedOut <= 1'b0;
        end else begin
            if (!wdActive)
                wdCnt <= '0;
            else if (!timedOut)
                wdCnt <= wdCnt + WdW'(1);
            if (wdHit)
                timedOut <= 1'b1;
        end
    end
`else
    assign wdHit = 1'b0;
    assign hold  = 1'b0;
`endif

    always_comb begin
        stateNext    = state;
        burstCntNext = burstCnt;
        errSet       = 1'b0;
        pathReady    = 1'b0;
        pathRelease  = 1'b0;
        unique case (state)
            IDLE: begin
                if (io.PathStart) begin
                    stateNext    = FILL;
                    burstCntNext = '0;
                end
            end
            FILL: begin
                errSet = io.PathStart;
                if (io.FillValid) begin
                    burstCntNext = burstCnt + CntW'(1);
                    if (burstCnt == LastBurst) begin
                        stateNext = VERIFY;
                        pathReady = 1'b1;
                    end
                end
            end
            VERIFY: begin
                errSet = io.PathStart || io.FillValid;
                if (io.PathDone && settled)
                    stateNext = RELEASE;
            end
            RELEASE: begin
                errSet      = io.PathStart || io.FillValid;
                pathRelease = 1'b1;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // a timed-out sequencer freezes in place and emits no pulses
        if (hold) begin
            stateNext    = state;
            burstCntNext = burstCnt;
            pathReady    = 1'b0;
            pathRelease  = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            burstCnt <= '0;
            settled  <= 1'b0;
            seqErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            burstCnt <= burstCntNext;
            settled  <= (state == VERIFY);
            if (errSet || wdHit)
                seqErr <= 1'b1;
        end
    end

    assign io.PathReady   = pathReady;
    assign io.PathRelease = pathRelease;
    assign io.SeqError    = seqErr;

    iv_boi_latch #(
        .LvlW (LvlW),
        .BidW (ORAML + 1)
    ) uBoi (
        .Clock    (Clock),
        .Reset    (Reset),
        .ROIValid (io.ROIValid),
        .ROIReady (io.ROIReady),
        .levelIn  (io.ROILevelIn),
        .bvIn     (io.ROIBVIn),
        .bidIn    (io.ROIBIDIn),
        .BOIReady (io.BOIReady),
        .level    (io.ROILevel),
        .bv       (io.ROIBV),
        .bid      (io.ROIBID),
        .BOIDone  (io.BOIDone),
        .busy     (boiBusy)
    );

endmodule

// File: tb/tb_iv_path_sequencer.sv
// Scoreboard bench for iv_path_sequencer (ORAML=2, 5 bursts per bucket).
module tb_iv_path_sequencer;

    localparam int ORAML = 2;

    typedef struct {
        int          c;
        logic [1:0]  lvl;
        logic [63:0] bv;
        logic [2:0]  bid;
    } boiExp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int      qPR[$];
    int      qRel[$];
    boiExp_t qBoi[$];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    iv_path_sequencer_if #(.ORAML(ORAML)) bus();

    iv_path_sequencer #(
        .ORAML            (ORAML),
        .BktSize_DRBursts (5),
        .TimeoutCycles    (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .io    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".PathReady"},   bus.PathReady, 0);
        chk({tag, ".PathRelease"}, bus.PathRelease, 0);
        chk({tag, ".BOIReady"},    bus.BOIReady, 0);
        chk({tag, ".ROIReady"},    bus.ROIReady, 1);
        chk({tag, ".ROILevel"},    bus.ROILevel, 0);
        chk({tag, ".ROIBV"},       bus.ROIBV, 0);
        chk({tag, ".ROIBID"},      bus.ROIBID, 0);
        chk({tag, ".SeqError"},    bus.SeqError, 0);
    endtask

    task automatic fill(input int n, input bit expectReady);
        for (int i = 1; i <= n; i++) begin
            bus.FillValid = 1'b1;
            if (i == n && expectReady)
                qPR.push_back(cyc);
            step();
        end
        bus.FillValid = 1'b0;
    endtask

    task automatic doReset(input string tag);
        Reset = 1'b0;
        #1;
        chkReset(tag);
        step();
        Reset = 1'b1;
        step();
    endtask

    // Monitor: every output pulse must match the head of its queue
    always @(negedge Clock) begin
        int      e;
        boiExp_t b;
        if (bus.PathReady) begin
            checks++;
            if (qPR.size() == 0) begin
                errors++;
                $display("FAIL pathReady: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = qPR.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pathReady: pulse at cycle %0d expected %0d",
                             cyc, e);
                end
            end
        end
        if (bus.PathRelease) begin
            checks++;
            if (qRel.size() == 0) begin
                errors++;
                $display("FAIL pathRelease: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = qRel.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pathRelease: pulse at cycle %0d expected %0d",
                             cyc, e);
                end
            end
        end
        if (bus.BOIReady) begin
            checks++;
            if (qBoi.size() == 0) begin
                errors++;
                $display("FAIL boiReady: unexpected pulse at cycle %0d", cyc);
            end else begin
                b = qBoi.pop_front();
                if (b.c != cyc || bus.ROILevel !== b.lvl ||
                    bus.ROIBV !== b.bv || bus.ROIBID !== b.bid) begin
                    errors++;
                    $display("FAIL boiReady: cyc %0d lvl %0h bv %0h bid %0h expected cyc %0d lvl %0h bv %0h bid %0h",
                             cyc, bus.ROILevel, bus.ROIBV, bus.ROIBID,
                             b.c, b.lvl, b.bv, b.bid);
                end
            end
        end
    end

    initial begin
        bus.FillValid  = 1'b0;
        bus.PathStart  = 1'b0;
        bus.PathDone   = 1'b0;
        bus.ROIValid   = 1'b0;
        bus.ROILevelIn = '0;
        bus.ROIBVIn    = '0;
        bus.ROIBIDIn   = '0;
        bus.BOIDone    = 1'b0;

        #12;
        chkReset("por");
        step();
        Reset = 1'b1;
        step();

        // Basic path; an unsettled PathDone right after PathReady is ignored
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(15, 1);
        bus.PathDone = 1'b1;
        step();
        bus.PathDone = 1'b0;
        step();
        bus.PathDone = 1'b1;
        qRel.push_back(cyc + 1);
        step();
        bus.PathDone = 1'b0;
        step();
        chk("basic.SeqError", bus.SeqError, 0);

        // Overrun burst after the path filled is a sticky error
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(15, 1);
        chk("overrun.before", bus.SeqError, 0);
        bus.FillValid = 1'b1;
        step();
        bus.FillValid = 1'b0;
        chk("overrun.set", bus.SeqError, 1);
        step();
        bus.PathDone = 1'b1;
        qRel.push_back(cyc + 1);
        step();
        bus.PathDone = 1'b0;
        step();
        step();
        chk("overrun.sticky", bus.SeqError, 1);
        doReset("clear1");

        // PathStart during FILL flags an error but does not restart the count
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(3, 0);
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        chk("restart.SeqError", bus.SeqError, 1);
        fill(12, 1);
        step();
        bus.PathDone = 1'b1;
        qRel.push_back(cyc + 1);
        step();
        bus.PathDone = 1'b0;
        step();
        doReset("clear2");

        // BOI handshake; early done and requests while busy are ignored
        chk("boi.readyIdle", bus.ROIReady, 1);
        bus.ROIValid   = 1'b1;
        bus.ROILevelIn = 2'd1;
        bus.ROIBVIn    = 64'h5;
        bus.ROIBIDIn   = 3'h3;
        qBoi.push_back('{cyc + 1, 2'd1, 64'h5, 3'h3});
        step();
        bus.ROILevelIn = 2'd2;
        bus.ROIBVIn    = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.ROIBIDIn   = 3'h7;
        chk("boi.readyBusy", bus.ROIReady, 0);
        step();
        bus.BOIDone = 1'b1;
        step();
        bus.BOIDone  = 1'b0;
        bus.ROIValid = 1'b0;
        chk("boi.earlyDone", bus.ROIReady, 0);
        chk("boi.holdLevel", bus.ROILevel, 1);
        chk("boi.holdBV",    bus.ROIBV, 64'h5);
        chk("boi.holdBID",   bus.ROIBID, 3'h3);
        bus.BOIDone = 1'b1;
        step();
        bus.BOIDone = 1'b0;
        chk("boi.readyAfter", bus.ROIReady, 1);
        step();

        // Simultaneous PathReady/BOIReady, BOI finishes first
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(13, 0);
        bus.FillValid  = 1'b1;
        bus.ROIValid   = 1'b1;
        bus.ROILevelIn = 2'd2;
        bus.ROIBVIn    = 64'hA;
        bus.ROIBIDIn   = 3'h5;
        qBoi.push_back('{cyc + 1, 2'd2, 64'hA, 3'h5});
        step();
        bus.ROIValid = 1'b0;
        qPR.push_back(cyc);
        step();
        bus.FillValid = 1'b0;
        step();
        bus.BOIDone = 1'b1;
        step();
        bus.BOIDone = 1'b0;
        chk("dual.boiFree", bus.ROIReady, 1);
        bus.PathDone = 1'b1;
        qRel.push_back(cyc + 1);
        step();
        bus.PathDone = 1'b0;
        chk("dual.SeqError", bus.SeqError, 0);
        step();

        // Async reset mid-FILL abandons the path
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(6, 0);
        bus.FillValid = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        chkReset("midFill");
        bus.FillValid = 1'b0;
        step();
        Reset = 1'b1;
        step();
        fill(15, 0);
        step();
        chk("noStart.SeqError", bus.SeqError, 0);
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(15, 1);
        step();
        bus.PathDone = 1'b1;
        qRel.push_back(cyc + 1);
        step();
        bus.PathDone = 1'b0;
        step();

`ifdef IVSEQ_WATCHDOG_EN
        // Verifier never answers: watchdog fires 16 cycles into VERIFY
        bus.PathStart = 1'b1;
        step();
        bus.PathStart = 1'b0;
        fill(15, 1);
        repeat (15) step();
        chk("wd.before", bus.SeqError, 0);
        step();
        chk("wd.fired", bus.SeqError, 1);
        doReset("wdClear");
`endif

        repeat (3) step();
        chk("sb.pathReadyLeft",   qPR.size(), 0);
        chk("sb.pathReleaseLeft", qRel.size(), 0);
        chk("sb.boiReadyLeft",    qBoi.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
